// File: rtl/regfile_2r1w_p_if.sv
// Bus bundle for regfile_2r1w_p: read request/response, write request, and
// bulk-clear control/status.
//   master: drives rd_en, addr_a/b, wr_en, wr_addr, wr_data, clr_req;
//           receives rd_data_a/b, rd_valid, busy, wr_drop.
//   slave : the register file side (mirror of master).
interface regfile_2r1w_p_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clr_req;
  logic              busy;
  logic              wr_drop;

  modport master (
    output rd_en, addr_a, addr_b, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data_a, rd_data_b, rd_valid, busy, wr_drop
  );

  modport slave (
    input  rd_en, addr_a, addr_b, wr_en, wr_addr, wr_data, clr_req,
    output rd_data_a, rd_data_b, rd_valid, busy, wr_drop
  );
endinterface

// File: rtl/regfile_2r1w_p.sv
// Two-read/one-write register file with registered reads, hardwired-zero
// entry 0 and a sequenced bulk-clear engine.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears every entry)
//   bus.slave  rd_en/addr_a/addr_b -> rd_data_a/rd_data_b/rd_valid (1-cycle latency)
//              wr_en/wr_addr/wr_data write port, wr_drop flags discarded writes
//              clr_req starts a clear of entries 1..DEPTH-1, busy while running
// Optional build macro: REGFILE_BYPASS_EN enables write-through forwarding of a
// same-cycle accepted write to a read port addressing the same entry.
module regfile_2r1w_p #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic             clk,
  input logic             rst_n,
  regfile_2r1w_p_if.slave bus
);

  localparam int unsigned       DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LastAddr  = {ADDR_W{1'b1}};

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_a_q;
  logic [DATA_W-1:0] rd_data_b_q;
  logic              rd_valid_q;
  logic              busy_q;
  logic              wr_drop_q;

  logic              idle;
  logic              wr_accept;
  logic              wr_dropped;
  logic              fwd_a;
  logic              fwd_b;
  logic [DATA_W-1:0] rd_word_a;
  logic [DATA_W-1:0] rd_word_b;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign idle       = (state_q == StIdle);
  // A clear request in the same cycle takes priority over the write.
  assign wr_accept  = idle && bus.wr_en && !bus.clr_req && (bus.wr_addr != '0);
  assign wr_dropped = bus.wr_en && (!idle || bus.clr_req);

`ifdef REGFILE_BYPASS_EN
  assign fwd_a = wr_accept && (bus.addr_a == bus.wr_addr);
  assign fwd_b = wr_accept && (bus.addr_b == bus.wr_addr);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  always_comb begin
    rd_word_a = '0;
    rd_word_b = '0;
    if (fwd_a) begin
      rd_word_a = bus.wr_data;
    end else if (bus.addr_a != '0) begin
      rd_word_a = mem_q[bus.addr_a];
    end
    if (fwd_b) begin
      rd_word_b = bus.wr_data;
    end else if (bus.addr_b != '0) begin
      rd_word_b = mem_q[bus.addr_b];
    end
  end

  // Single write port shared by the clear engine and the external writer.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = clr_ptr_q;
      mem_wdata = '0;
    end else if (wr_accept) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      clr_ptr_q   <= FirstAddr;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      wr_drop_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      wr_drop_q  <= wr_dropped;
      case (state_q)
        StIdle: begin
          // Reads are still serviced in the cycle a clear is requested.
          if (bus.rd_en) begin
            rd_data_a_q <= rd_word_a;
            rd_data_b_q <= rd_word_b;
            rd_valid_q  <= 1'b1;
          end
          if (bus.clr_req) begin
            state_q   <= StClear;
            busy_q    <= 1'b1;
            clr_ptr_q <= FirstAddr;
          end
        end
        StClear: begin
          if (clr_ptr_q == LastAddr) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            clr_ptr_q <= FirstAddr;
          end else begin
            clr_ptr_q <= clr_ptr_q + FirstAddr;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_data_a = rd_data_a_q;
  assign bus.rd_data_b = rd_data_b_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.busy      = busy_q;
  assign bus.wr_drop   = wr_drop_q;

endmodule

// File: doc/regfile_2r1w_p.md
# regfile_2r1w_p

Parametrised two-read/one-write register file, the next generation of the memory/decoder block feeding the datapath's A and B operand buses. It adds configurable data width and depth, registered reads with a valid strobe, a hardwired-zero entry 0, an asynchronous reset, and a sequenced bulk-clear engine with a busy flag. It sits between instruction decode (addresses) and the ALU operand registers.

## Interface
- DATA_W, 32, entry width in bits (≥1)
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (ADDR_W ≥ 1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  1  read request for both ports this cycle
- addr_a  in  ADDR_W  read address, port A
- addr_b  in  ADDR_W  read address, port B
- rd_data_a  out  DATA_W  registered read data, port A
- rd_data_b  out  DATA_W  registered read data, port B
- rd_valid  out  1  one-cycle strobe: rd_data_a/b updated this cycle
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- clr_req  in  1  start bulk clear of all entries
- busy  out  1  clear sequence in progress
- wr_drop  out  1  one-cycle strobe: a write with wr_en=1 was discarded

## Operation
- Reset (rst_n=0, async): all entries 0; rd_data_a/b=0; rd_valid=0; busy=0; wr_drop=0; FSM=IDLE; clear pointer=1.
- Entry 0: always reads 0; writes to address 0 are silently ignored (not a drop, wr_drop stays 0).
- Write: in IDLE, wr_en=1 with wr_addr≠0 stores wr_data at the rising edge.
- Read: in IDLE, rd_en=1 captures mem[addr_a], mem[addr_b] into rd_data_a/b at the edge; rd_valid=1 for that one cycle. rd_en=0: outputs hold last value, rd_valid=0.
- Same-cycle write and read of same address: see Configuration.
- FSM states:
  - IDLE: clr_req=1 → CLEAR, busy=1 next cycle, pointer=1. Otherwise service reads/writes.
  - CLEAR: each cycle write 0 to mem[pointer], pointer+1; when pointer=DEPTH-1 is cleared → IDLE. Pointer ADDR_W bits, no wrap beyond DEPTH-1.
- In CLEAR: wr_en=1 → write dropped, wr_drop=1; rd_en ignored (rd_valid=0, outputs hold); clr_req ignored.
- IDLE with clr_req=1 and wr_en=1 same cycle: clear wins, write dropped, wr_drop=1; rd_en same cycle still serviced with pre-clear contents.
- rst_n asserted mid-clear: immediate return to reset state; sequence not resumed.

## Timing
- Write latency: data visible to a read issued the cycle after the write edge.
- Read latency: 1 cycle (rd_en at edge N → data and rd_valid during cycle N+1).
- Clear: busy high for exactly DEPTH-1 cycles, starting the cycle after clr_req is sampled; first read accepted the edge busy falls returns 0 for every entry.
- wr_drop asserted the cycle after the dropped request edge, for one cycle.
- All outputs registered; no combinational path input→output.

## Configuration
- REGFILE_BYPASS_EN defined: read in IDLE with rd_en=1, wr_en=1, wr_addr≠0, addr_x==wr_addr returns wr_data on that port (write-through forwarding).
- Not defined: such a read returns the pre-write contents; new value visible from the next read onward.
- Address 0 and dropped writes are never forwarded in either build.

## Test plan
- Reset, then write 64→addr 1, 128→addr 2; read A=1,B=2 → rd_data_a=64, rd_data_b=128, rd_valid one cycle.
- Write 0xDEADBEEF→addr 0; read A=0,B=0 → both 0, wr_drop=0.
- Same-cycle write 0x55→addr 3 and read A=3 (prior 0x11): with REGFILE_BYPASS_EN → 0x55; without → 0x11; next read → 0x55 both builds.
- Fill all entries with address value, pulse clr_req → busy high exactly DEPTH-1 (31) cycles; write during busy → wr_drop=1; after busy falls, reads of 1..31 all 0.
- Assert rst_n=0 midway through clear, release → busy=0, all entries 0, read of addr 5 returns 0.
- DATA_W=8, ADDR_W=2 instance: write 0xFF→addr 3, read → 0xFF; clear busy lasts 3 cycles.
